// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - rename-stage sizing constants and shared free-list types
package rename_pkg;
    localparam int PHYS_REGS = 64;
    localparam int ARCH_REGS = 32;
    localparam int NUM_CKPT  = 4;
    localparam int DEPTH     = PHYS_REGS - ARCH_REGS;
    localparam int TAG_W     = $clog2(PHYS_REGS);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int PTR_W     = IDX_W + 1;
    localparam int CKPT_W    = $clog2(NUM_CKPT);
    localparam int CNT_W     = $clog2(DEPTH + 1);

    typedef logic [TAG_W-1:0]  preg_t;
    typedef logic [CKPT_W-1:0] ckpt_id_t;
    typedef logic [PTR_W-1:0]  fl_ptr_t;
    typedef logic [CNT_W-1:0]  fl_cnt_t;

    typedef enum logic [1:0] {
        FL_INIT,
        FL_RUN,
        FL_RECOVER
    } fl_state_e;
endpackage

// File: rtl/free_list_ram.sv
// rtl/free_list_ram.sv - free-list storage, one sync write port and one async read port
module free_list_ram
    import rename_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  preg_t            wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output preg_t            rd_data
);
    preg_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/free_list_ctrl.sv
// rtl/free_list_ctrl.sv - physical-register free list with branch checkpoints and rollback
module free_list_ctrl
    import rename_pkg::*;
#(
    parameter bit ASSERT_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     alloc_req,
    output logic     alloc_gnt,
    output preg_t    alloc_preg,
    input  logic     free_valid,
    input  preg_t    free_preg,
    input  logic     ckpt_req,
    output logic     ckpt_gnt,
    output ckpt_id_t ckpt_id,
    input  logic     ckpt_release,
    input  ckpt_id_t ckpt_release_id,
    input  logic     recover,
    input  ckpt_id_t recover_id,
    output fl_cnt_t  free_count,
    output logic     empty,
    output logic     busy
);
    fl_state_e           state;
    fl_ptr_t             head, tail;
    fl_cnt_t             cnt;
    logic [NUM_CKPT-1:0] ck_valid;
    ckpt_id_t            ck_head, ck_tail;
    fl_ptr_t             snap [NUM_CKPT];

    logic                in_init, in_run, full;
    logic                init_last, free_ok, wr_en, rel_ok, rec_ok;
    preg_t               ram_rd, wr_data;
    logic [NUM_CKPT-1:0] valid_rel, valid_nxt;
    ckpt_id_t            ck_head_rel;
    fl_ptr_t             head_nxt, tail_nxt;

    assign in_init    = (state == FL_INIT);
    assign in_run     = (state == FL_RUN);
    assign empty      = (cnt == '0);
    assign full       = (cnt == fl_cnt_t'(DEPTH));
    assign busy       = ~in_run;
    assign free_count = cnt;

    assign alloc_gnt  = alloc_req & ~empty & ~recover & in_run;
    assign alloc_preg = alloc_gnt ? ram_rd : '0;
    // The slot at ck_tail is still live only when the queue has wrapped full.
    assign ckpt_gnt   = ckpt_req & ~ck_valid[ck_tail] & ~recover & in_run;
    assign ckpt_id    = ck_tail;

    assign init_last  = in_init && (tail == fl_ptr_t'(DEPTH - 1));
    assign free_ok    = free_valid & ~full & ~in_init;
    assign wr_en      = in_init | free_ok;
    assign wr_data    = in_init ? preg_t'(ARCH_REGS) + preg_t'(tail[IDX_W-1:0]) : free_preg;
    assign rel_ok     = ckpt_release & ck_valid[ck_head] & (ckpt_release_id == ck_head);

    free_list_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (tail[IDX_W-1:0]),
        .wr_data (wr_data),
        .rd_addr (head[IDX_W-1:0]),
        .rd_data (ram_rd)
    );

    // Release retires the oldest entry first; a same-cycle recover then truncates what remains.
    always_comb begin
        valid_rel   = ck_valid;
        ck_head_rel = ck_head;
        if (rel_ok) begin
            valid_rel[ck_head] = 1'b0;
            ck_head_rel        = ck_head + 1'b1;
        end
        rec_ok    = recover & ~in_init & valid_rel[recover_id];
        valid_nxt = valid_rel;
        if (rec_ok) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (ckpt_id_t'(ckpt_id_t'(i) - ck_head_rel) >= ckpt_id_t'(recover_id - ck_head_rel)) begin
                    valid_nxt[i] = 1'b0;
                end
            end
        end else if (ckpt_gnt) begin
            valid_nxt[ck_tail] = 1'b1;
        end
        head_nxt = rec_ok ? snap[recover_id] : head + fl_ptr_t'(alloc_gnt);
        tail_nxt = tail + fl_ptr_t'(wr_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FL_INIT;
            head     <= '0;
            tail     <= '0;
            cnt      <= '0;
            ck_valid <= '0;
            ck_head  <= '0;
            ck_tail  <= '0;
        end else begin
            head     <= head_nxt;
            tail     <= tail_nxt;
            ck_valid <= valid_nxt;
            ck_head  <= ck_head_rel;
            if (rec_ok) begin
                ck_tail <= recover_id;
            end else if (ckpt_gnt) begin
                ck_tail <= ck_tail + 1'b1;
            end
            unique case (state)
                FL_INIT: begin
                    if (init_last) begin
                        state <= FL_RUN;
                        cnt   <= fl_cnt_t'(DEPTH);
                    end
                end
                FL_RUN, FL_RECOVER: begin
                    state <= rec_ok ? FL_RECOVER : FL_RUN;
                    cnt   <= fl_cnt_t'(tail_nxt - head_nxt);
                end
                default: state <= FL_INIT;
            endcase
        end
    end

    // Snapshot holds head after this cycle's grant so the branch keeps its own destination.
    always_ff @(posedge clk) begin
        if (ckpt_gnt) begin
            snap[ck_tail] <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (ASSERT_EN && !rst) begin
            assert (!(free_valid && in_init)) else $error("free_valid during INIT dropped");
            assert (!(free_valid && !in_init && full)) else $error("free_valid while full dropped");
            assert (!ckpt_release || rel_ok) else $error("ckpt_release id not oldest live");
            assert (!recover || rec_ok) else $error("recover_id not live");
        end
    end
endmodule

// File: tb/tb_free_list_ctrl.sv
// tb/tb_free_list_ctrl.sv - directed self-checking bench for free_list_ctrl
module tb_free_list_ctrl;
    import rename_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    logic     alloc_req, alloc_gnt;
    preg_t    alloc_preg, free_preg;
    logic     free_valid, ckpt_req, ckpt_gnt, ckpt_release, recover;
    ckpt_id_t ckpt_id, ckpt_release_id, recover_id;
    fl_cnt_t  free_count;
    logic     empty, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    free_list_ctrl #(.ASSERT_EN(1'b0)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_gnt       (alloc_gnt),
        .alloc_preg      (alloc_preg),
        .free_valid      (free_valid),
        .free_preg       (free_preg),
        .ckpt_req        (ckpt_req),
        .ckpt_gnt        (ckpt_gnt),
        .ckpt_id         (ckpt_id),
        .ckpt_release    (ckpt_release),
        .ckpt_release_id (ckpt_release_id),
        .recover         (recover),
        .recover_id      (recover_id),
        .free_count      (free_count),
        .empty           (empty),
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        alloc_req       = 1'b0;
        free_valid      = 1'b0;
        free_preg       = '0;
        ckpt_req        = 1'b0;
        ckpt_release    = 1'b0;
        ckpt_release_id = '0;
        recover         = 1'b0;
        recover_id      = '0;
    endtask

    task automatic do_reset(input bit check_init);
        cyc();
        clr();
        rst = 1'b1;
        cyc();
        cyc();
        alloc_req = 1'b1;
        ckpt_req  = 1'b1;
        #2;
        if (check_init) begin
            chk("rst_alloc_gnt", alloc_gnt, 0);
            chk("rst_alloc_preg", alloc_preg, 0);
            chk("rst_ckpt_gnt", ckpt_gnt, 0);
            chk("rst_free_count", free_count, 0);
            chk("rst_empty", empty, 1);
        end
        clr();
        rst = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #2;
            if (check_init) chk("init_busy", busy, 1);
            cyc();
        end
        #2;
        chk("init_done_busy", busy, 0);
        chk("init_done_count", free_count, 32);
    endtask

    initial begin
        clr();
        rst = 1'b1;

        // 1: reset, refill, back-to-back allocation
        do_reset(1'b1);
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t1_gnt", alloc_gnt, 1);
            chk("t1_preg", alloc_preg, 32 + i);
            cyc();
        end
        clr();

        // 2: drain to empty, free one, reallocate it
        do_reset(1'b0);
        alloc_req = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #2;
            chk("t2_preg", alloc_preg, 32 + i);
            cyc();
        end
        #2;
        chk("t2_empty", empty, 1);
        chk("t2_gnt33", alloc_gnt, 0);
        chk("t2_count0", free_count, 0);
        clr();
        free_valid = 1'b1;
        free_preg  = 6'd5;
        cyc();
        clr();
        #2;
        chk("t2_count1", free_count, 1);
        alloc_req = 1'b1;
        #2;
        chk("t2_regnt", alloc_gnt, 1);
        chk("t2_repreg", alloc_preg, 5);
        cyc();
        clr();
        #2;
        chk("t2_reempty", empty, 1);

        // 3: checkpoint then mispredict rollback
        do_reset(1'b0);
        alloc_req = 1'b1;
        repeat (2) cyc();
        clr();
        ckpt_req = 1'b1;
        #2;
        chk("t3_ckgnt", ckpt_gnt, 1);
        chk("t3_ckid", ckpt_id, 0);
        cyc();
        clr();
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("t3_preg", alloc_preg, 34 + i);
            cyc();
        end
        recover    = 1'b1;
        recover_id = 2'd0;
        #2;
        chk("t3_rec_gnt", alloc_gnt, 0);
        cyc();
        recover = 1'b0;
        #2;
        chk("t3_recover_busy", busy, 1);
        chk("t3_recover_gnt", alloc_gnt, 0);
        cyc();
        #2;
        chk("t3_after_busy", busy, 0);
        chk("t3_after_gnt", alloc_gnt, 1);
        chk("t3_after_preg", alloc_preg, 34);
        chk("t3_after_count", free_count, 30);
        clr();

        // 4: checkpoint queue full, wrap, bad release ignored
        do_reset(1'b0);
        ckpt_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t4_gnt", ckpt_gnt, 1);
            chk("t4_id", ckpt_id, i);
            cyc();
        end
        #2;
        chk("t4_full_gnt", ckpt_gnt, 0);
        clr();
        ckpt_release = 1'b1;
        ckpt_release_id = 2'd0;
        cyc();
        clr();
        ckpt_req = 1'b1;
        #2;
        chk("t4_wrap_gnt", ckpt_gnt, 1);
        chk("t4_wrap_id", ckpt_id, 0);
        cyc();
        clr();
        ckpt_release = 1'b1;
        ckpt_release_id = 2'd2;
        cyc();
        clr();
        ckpt_req = 1'b1;
        #2;
        chk("t4_badrel_gnt", ckpt_gnt, 0);
        clr();
        ckpt_release = 1'b1;
        ckpt_release_id = 2'd1;
        cyc();
        clr();
        ckpt_req = 1'b1;
        #2;
        chk("t4_goodrel_gnt", ckpt_gnt, 1);
        chk("t4_goodrel_id", ckpt_id, 1);
        cyc();
        clr();

        // 5: recover overrides alloc/ckpt, same-cycle free still lands at tail
        do_reset(1'b0);
        alloc_req = 1'b1;
        repeat (2) cyc();
        clr();
        ckpt_req = 1'b1;
        cyc();
        clr();
        alloc_req = 1'b1;
        cyc();
        recover    = 1'b1;
        recover_id = 2'd0;
        ckpt_req   = 1'b1;
        free_valid = 1'b1;
        free_preg  = 6'd9;
        #2;
        chk("t5_alloc_gnt", alloc_gnt, 0);
        chk("t5_ckpt_gnt", ckpt_gnt, 0);
        cyc();
        clr();
        #2;
        chk("t5_busy", busy, 1);
        chk("t5_count", free_count, 31);
        cyc();
        alloc_req = 1'b1;
        for (int i = 0; i < 30; i++) begin
            #2;
            chk("t5_preg", alloc_preg, 34 + i);
            cyc();
        end
        #2;
        chk("t5_freed_gnt", alloc_gnt, 1);
        chk("t5_freed_preg", alloc_preg, 9);
        cyc();
        clr();
        #2;
        chk("t5_empty", empty, 1);

        // 6: reset during RECOVER restarts the refill
        do_reset(1'b0);
        ckpt_req = 1'b1;
        cyc();
        clr();
        alloc_req = 1'b1;
        cyc();
        clr();
        recover    = 1'b1;
        recover_id = 2'd0;
        cyc();
        clr();
        #2;
        chk("t6_in_recover", busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        alloc_req = 1'b1;
        #2;
        chk("t6_busy", busy, 1);
        chk("t6_count", free_count, 0);
        chk("t6_gnt", alloc_gnt, 0);
        clr();
        repeat (32) cyc();
        #2;
        chk("t6_done_busy", busy, 0);
        chk("t6_done_count", free_count, 32);
        alloc_req = 1'b1;
        ckpt_req  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("t6_ckgnt", ckpt_gnt, 1);
            chk("t6_ckid", ckpt_id, i);
            chk("t6_preg", alloc_preg, 32 + i);
            cyc();
        end
        #2;
        chk("t6_ckfull", ckpt_gnt, 0);
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/free_list_ctrl.md
Name: free_list_ctrl

Overview:
Controller for the physical-register free list in the rename stage. It owns the circular free-list storage and sequences its pointers. It grants one physical register per cycle to rename and accepts one released register per cycle from commit. It also snapshots the allocation pointer per in-flight branch and rolls it back on mispredict.

Parameters:
PHYS_REGS, 64, total physical registers
ARCH_REGS, 32, architectural registers; regs 0..ARCH_REGS-1 are mapped at reset
NUM_CKPT, 4, max outstanding branch checkpoints
(derived) DEPTH = PHYS_REGS-ARCH_REGS; TAG_W = clog2(PHYS_REGS); PTR_W = clog2(DEPTH)+1; CKPT_W = clog2(NUM_CKPT)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
alloc_req  in  1  rename requests a destination preg
alloc_gnt  out  1  allocation granted this cycle (combinational)
alloc_preg  out  TAG_W  granted preg; valid when alloc_gnt
free_valid  in  1  commit releases a preg
free_preg  in  TAG_W  released preg
ckpt_req  in  1  rename of a branch requests a snapshot
ckpt_gnt  out  1  snapshot taken (combinational)
ckpt_id  out  CKPT_W  id of the snapshot; valid when ckpt_gnt
ckpt_release  in  1  oldest branch resolved correctly
ckpt_release_id  in  CKPT_W  must equal the oldest live id
recover  in  1  mispredict; roll back to recover_id
recover_id  in  CKPT_W  checkpoint to restore
free_count  out  clog2(DEPTH+1)  registered count of free pregs
empty  out  1  free_count==0
busy  out  1  high in INIT or RECOVER

Behaviour:
- Reset: state<=INIT, head=0, tail=0, all checkpoints invalid. Outputs: alloc_gnt=0, ckpt_gnt=0, alloc_preg=0, free_count=0, empty=1, busy=1. Reset asserted in any state, including mid-RECOVER, returns to INIT.
- INIT: writes entry i = ARCH_REGS+i, one per cycle, for DEPTH cycles; tail increments each cycle. No grants in INIT. A free_valid in INIT is illegal: assertion fires and the free is dropped. On the last write, the next state is RUN with head=0, tail=DEPTH (wrap bit set) and free_count=DEPTH.
- Pointers are PTR_W wide; index = low bits. free_count = tail-head (mod 2^PTR_W). empty: count==0. full: count==DEPTH.
- RUN, allocate: alloc_gnt = alloc_req & ~empty & ~recover. Zero latency; alloc_preg = storage[head]. On grant, head+1.
- Free: accepted in RUN and RECOVER. Writes storage[tail], tail+1. Free when full: assertion fires, free is dropped.
- Alloc and free in the same cycle: both apply. No bypass, so a free does not satisfy an alloc in the same cycle when the list is empty.
- Checkpoints are a circular queue in program order (ck_head = oldest, ck_tail = next).
  - ckpt_gnt = ckpt_req & ~ckpt_full & ~recover & state==RUN.
  - Snapshot value = head after this cycle's allocation, so the branch's own dest is kept.
  - ckpt_id = ck_tail.
- ckpt_release: frees ck_head, ck_head+1. If the id is mismatched or no checkpoint is live: assertion fires, release is ignored.
- recover with a live recover_id: head <= snap[recover_id]; ck_tail <= recover_id, invalidating it and all younger checkpoints; state <= RECOVER for one cycle.
  - A recover_id that is not live is ignored and an assertion fires.
  - recover overrides alloc and ckpt_req in the same cycle. A free in the same cycle still applies. A release in the same cycle applies before the truncate.
- RECOVER: alloc_gnt=0, ckpt_gnt=0, busy=1; next state is RUN.
- Rollback correctness: entries between the snapshot head and the current head are not overwritten, because tail cannot lap head (count ≤ DEPTH).

Decomposition:
- rename_pkg holds:
  - PHYS_REGS, ARCH_REGS, NUM_CKPT
  - preg_t (logic [TAG_W-1:0]), ckpt_id_t
  - fl_state_e {FL_INIT, FL_RUN, FL_RECOVER}
  - fl_ptr_t
- One sub-module, free_list_ram: DEPTH x TAG_W, one synchronous write port, one asynchronous read port, no reset on the array.
- Checkpoint storage and the FSM stay inline.

Test Plan:
1. Assert rst 2 cycles, release -> busy=1 for 32 cycles; then busy=0, free_count=32; back-to-back alloc_req returns 32,33,34.
2. Allocate 32 times -> empty=1; 33rd request gives alloc_gnt=0. Free preg 5 -> free_count=1; next alloc returns 5.
3. Alloc 32,33; ckpt_req -> ckpt_id=0. Alloc 34,35,36; recover id0 -> next cycle busy=1, alloc_gnt=0; the cycle after, alloc_preg=34, free_count=30.
4. Four ckpt_req -> ids 0..3; fifth gives ckpt_gnt=0. Release id0, ckpt_req -> id=0 (wrap). Release id2 while oldest is id1 -> assertion, state unchanged.
5. recover, alloc_req, ckpt_req and free_valid(preg 9) in the same cycle -> alloc_gnt=0, ckpt_gnt=0; free accepted and 9 appears at tail; head restored.
6. rst asserted during RECOVER -> next cycle state INIT, free_count=0, checkpoints invalid; INIT refill repeats with 32,33,....
